fir_mse_monitor: RTL

Error-metric stage placed directly downstream of the approximate 9-tap FIR and its exact-arithmetic twin. It consumes the two time-aligned 16-bit signed filter outputs sample by sample, squares their difference, and accumulates the squared error over a window of 2^LOG2N accepted samples. At the end of the window it reports the sum of squared errors (SSE) and the mean squared error (MSE) for the adder under test.

---
 rtl/fir_mse_pkg.sv | 17 +
 rtl/fir_mse_monitor_if.sv | 32 +++
 rtl/fir_mse_sq.sv | 69 ++++++
 rtl/fir_mse_monitor.sv | 129 ++++++++++++
 4 files changed

// File: rtl/fir_mse_pkg.sv
// rtl/fir_mse_pkg.sv - shared types and width constants for the FIR MSE monitor
// Contents: FSM state enum, default sample width / window size, derived widths.
package fir_mse_pkg;

  localparam int DW_DEFAULT    = 16;
  localparam int LOG2N_DEFAULT = 10;
  localparam int SQW           = 2 * DW_DEFAULT;
  localparam int ACCW          = SQW + LOG2N_DEFAULT;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/fir_mse_monitor_if.sv
// rtl/fir_mse_monitor_if.sv - control, sample and result bundle of the FIR MSE monitor
// Signals: start, in_valid, y_approx, y_exact (toward the monitor);
//          busy, done, sse, mse, max_abs_err (from the monitor).
// Modports: master = filter/test side, slave = monitor side.
interface fir_mse_monitor_if
  import fir_mse_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int LOG2N = LOG2N_DEFAULT
);

  logic                    start;
  logic                    in_valid;
  logic signed [DW-1:0]    y_approx;
  logic signed [DW-1:0]    y_exact;
  logic                    busy;
  logic                    done;
  logic [2*DW+LOG2N-1:0]   sse;
  logic [2*DW-1:0]         mse;
  logic [DW-1:0]           max_abs_err;

  modport master (
    output start, in_valid, y_approx, y_exact,
    input  busy, done, sse, mse, max_abs_err
  );

  modport slave (
    input  start, in_valid, y_approx, y_exact,
    output busy, done, sse, mse, max_abs_err
  );

endinterface

// File: rtl/fir_mse_sq.sv
// rtl/fir_mse_sq.sv - two-stage |difference| and square pipeline
// Ports: clk, rstN (async active-low), clear (drops in-flight valids),
//        in_valid/y_approx/y_exact (accepted sample), sq_valid/sq (P2 result),
//        mag (P2 |diff|, present only when MSE_MAXERR_EN is defined).
module fir_mse_sq
  import fir_mse_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] y_approx,
  input  logic signed [DW-1:0] y_exact,
  output logic                 sq_valid,
  output logic [2*DW-1:0]      sq
`ifdef MSE_MAXERR_EN
  ,
  output logic [DW-1:0]        mag
`endif
);

  localparam int SQ_W = 2 * DW;

  logic [DW:0]   diff;
  logic [DW-1:0] diff_mag;
  logic          p1_valid;
  logic [DW-1:0] p1_mag;

  // |diff| never exceeds 2^DW-1, so negating only the low DW bits is exact.
  always_comb begin
    diff     = {y_approx[DW-1], y_approx} - {y_exact[DW-1], y_exact};
    diff_mag = diff[DW] ? (~diff[DW-1:0] + DW'(1)) : diff[DW-1:0];
  end

  // P1 keeps the magnitude: the square and the max tracker only need |diff|.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      p1_valid <= 1'b0;
      p1_mag   <= '0;
    end else if (clear) begin
      p1_valid <= 1'b0;
    end else begin
      p1_valid <= in_valid;
      if (in_valid) p1_mag <= diff_mag;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sq_valid <= 1'b0;
      sq       <= '0;
    end else if (clear) begin
      sq_valid <= 1'b0;
    end else begin
      sq_valid <= p1_valid;
      if (p1_valid) sq <= SQ_W'(p1_mag) * SQ_W'(p1_mag);
    end
  end

`ifdef MSE_MAXERR_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)         mag <= '0;
    else if (p1_valid) mag <= p1_mag;
  end
`endif

endmodule

// File: rtl/fir_mse_monitor.sv
// rtl/fir_mse_monitor.sv - windowed SSE/MSE of approximate vs exact FIR output
// Ports: clk, rstN (async active-low), bus (fir_mse_monitor_if.slave):
//        start arms a window of 2^LOG2N accepted samples; busy while measuring;
//        done pulses one cycle when sse/mse/max_abs_err are updated and held.
// Build option: MSE_MAXERR_EN enables window-maximum |diff| tracking; otherwise
//        max_abs_err reads 0.
module fir_mse_monitor
  import fir_mse_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int LOG2N = LOG2N_DEFAULT
) (
  input logic              clk,
  input logic              rstN,
  fir_mse_monitor_if.slave bus
);

  localparam int SQ_W  = 2 * DW;
  localparam int ACC_W = SQ_W + LOG2N;

  state_t             state, state_nxt;
  logic               clear, accept;
  logic [LOG2N-1:0]   cnt;
  logic               drain_cnt;
  logic [ACC_W-1:0]   acc;
  logic               sq_valid;
  logic [SQ_W-1:0]    sq;
  logic               done_q;
  logic [ACC_W-1:0]   sse_q;
  logic [SQ_W-1:0]    mse_q;

`ifdef MSE_MAXERR_EN
  logic [DW-1:0] mag, max_q, max_out_q;
`endif

  fir_mse_sq #(.DW(DW)) u_sq (
    .clk      (clk),
    .rstN     (rstN),
    .clear    (clear),
    .in_valid (accept),
    .y_approx (bus.y_approx),
    .y_exact  (bus.y_exact),
    .sq_valid (sq_valid),
    .sq       (sq)
`ifdef MSE_MAXERR_EN
    ,
    .mag      (mag)
`endif
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          clear     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.in_valid) begin
          accept = 1'b1;
          if (cnt == '1) state_nxt = DRAIN;
        end
      end
      // Second DRAIN cycle: the last square lands in acc at this edge.
      DRAIN:   if (drain_cnt) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt       <= '0;
      drain_cnt <= 1'b0;
      acc       <= '0;
    end else begin
      drain_cnt <= (state == DRAIN);
      if (clear)       cnt <= '0;
      else if (accept) cnt <= cnt + 1'b1;
      if (clear)         acc <= '0;
      else if (sq_valid) acc <= acc + ACC_W'(sq);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      done_q <= 1'b0;
      sse_q  <= '0;
      mse_q  <= '0;
    end else begin
      done_q <= (state == DONE);
      if (state == DONE) begin
        sse_q <= acc;
        mse_q <= acc[ACC_W-1:LOG2N];
      end
    end
  end

`ifdef MSE_MAXERR_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      max_q     <= '0;
      max_out_q <= '0;
    end else begin
      if (clear)                          max_q <= '0;
      else if (sq_valid && (mag > max_q)) max_q <= mag;
      if (state == DONE) max_out_q <= max_q;
    end
  end
  assign bus.max_abs_err = max_out_q;
`else
  assign bus.max_abs_err = '0;
`endif

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.sse  = sse_q;
  assign bus.mse  = mse_q;

endmodule
